updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter with synchronous load, count enable, selectable wrap or saturate behaviour, and a one-cycle boundary pulse. It generalises the existing 4-bit up counter in three ways: configurable width and modulus, bidirectional counting, and a boundary event for cascading counters or timing datapath events. It is a leaf block, instantiated directly by control logic and testbenches.

## Interface
- WIDTH, 4, counter register width in bits (≥1)
- MODULUS, 16, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH
- SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- din  input  WIDTH  load value
- count  output  WIDTH  registered count value
- carry  output  1  registered one-cycle boundary pulse
- at_max  output  1  combinational: count == MODULUS-1
- at_min  output  1  combinational: count == 0

## Operation
- Reset (reset=0): count=0 and carry=0 immediately, independent of clk. Consequently at_min=1 and at_max=0.
- Priority per rising edge: load > en > hold.
- load=1:
  - count ← din if din < MODULUS, else count ← MODULUS-1 (clamp).
  - carry ← 0.
  - en and up are ignored.
- load=0, en=0: count holds and carry ← 0.
- load=0, en=1, up=1:
  - If count < MODULUS-1: count ← count+1, carry ← 0.
  - If count == MODULUS-1 and SATURATE=0: count ← 0, carry ← 1.
  - If count == MODULUS-1 and SATURATE=1: count holds, carry ← 1.
- load=0, en=1, up=0:
  - If count > 0: count ← count-1, carry ← 0.
  - If count == 0 and SATURATE=0: count ← MODULUS-1, carry ← 1.
  - If count == 0 and SATURATE=1: count holds, carry ← 1.
- Arithmetic is performed in WIDTH bits.
  - Count never leaves 0..MODULUS-1, including when MODULUS = 2^WIDTH.
  - No intermediate value is wider than WIDTH+1 bits.
- Out-of-range state cannot arise from any input sequence. Any value ≥ MODULUS is treated as MODULUS-1 on the next enabled step.

## Timing
- Inputs are sampled on the rising edge of clk. count and carry update on that same edge and are visible for the following cycle.
- Latency is 1 cycle from an en, load or up change to the count change.
- carry is high for exactly the one cycle in which the post-wrap or held-at-bound count is presented.
  - Under continuous en at the bound with SATURATE=1, carry stays high on every such cycle.
- at_max and at_min follow count combinationally, with no extra cycle.
- Reset asserted mid-operation clears count and carry asynchronously. A load or step pending in that cycle is discarded.
- Reset deasserted: the first rising edge with reset=1 performs a normal load/step/hold.
- A direction reversal takes effect on the next edge, with no dead cycle.

## Test plan
- Reset: drive reset=0 at any count, e.g. 5, with clk idle → count=0, carry=0, at_min=1 without a clock edge. Release reset and apply 1 edge with en=1, up=1 → count=1.
- Default wrap (WIDTH=4, MODULUS=16): en=1, up=1 for 16 edges → count 1..15, then 0.
  - carry=1 only in the cycle showing 0.
  - at_max=1 only in the cycle showing 15.
- Non-power-of-two (WIDTH=4, MODULUS=10):
  - Up from 9 → 0 with carry=1.
  - Down from 0 → 9 with carry=1.
  - Down from 5 → 4 with carry=0.
- Saturate (MODULUS=10, SATURATE=1):
  - 12 up edges from 0 → count reaches 9 and holds; carry=1 on each of the last 3 edges.
  - 2 down edges from 0 → count stays 0 with carry=1.
- Load priority:
  - load=1, din=7 with en=1, up=1 → count=7, not 8, and carry=0.
  - With MODULUS=10, din=12 → count=9.
- Hold and reset: en=0 for 5 edges at count=3 → stays 3 with carry=0. Then assert reset mid-cycle → count=0 immediately.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: count controls in, count state out.
interface updown_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up, load, din,
    input  count, carry, at_max, at_min
  );

  modport slave (
    input  en, up, load, din,
    output count, carry, at_max, at_min
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clamped load, wrap or saturate at the
// bounds, and a registered one-cycle boundary pulse for cascading.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_din_clamped;

  // Any stored value beyond the range steps as if it were the top bound.
  assign w_cur         = (r_count > MAX_VAL) ? MAX_VAL : r_count;
  assign w_din_clamped = (bus.din > MAX_VAL) ? MAX_VAL : bus.din;

  always_comb begin
    w_count_nxt = r_count;
    w_carry_nxt = 1'b0;
    if (bus.load) begin
      w_count_nxt = w_din_clamped;
    end else if (bus.en) begin
      if (bus.up) begin
        if (w_cur == MAX_VAL) begin
          w_count_nxt = SATURATE ? MAX_VAL : '0;
          w_carry_nxt = 1'b1;
        end else begin
          w_count_nxt = w_cur + WIDTH'(1);
        end
      end else begin
        if (w_cur == '0) begin
          w_count_nxt = SATURATE ? '0 : MAX_VAL;
          w_carry_nxt = 1'b1;
        end else begin
          w_count_nxt = w_cur - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign bus.count  = r_count;
  assign bus.carry  = r_carry;
  assign bus.at_max = (r_count == MAX_VAL);
  assign bus.at_min = (r_count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: modulo-16 wrap, modulo-10 wrap and
// modulo-10 saturating instances driven from one clock and reset.
module tb_updown_mod_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  updown_mod_counter_if #(.WIDTH(4)) bus16  ();
  updown_mod_counter_if #(.WIDTH(4)) bus10  ();
  updown_mod_counter_if #(.WIDTH(4)) bus10s ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_mod16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_mod10 (
    .clk(clk), .reset(reset), .bus(bus10)
  );
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_mod10s (
    .clk(clk), .reset(reset), .bus(bus10s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus16.en  = 1'b0; bus16.up  = 1'b0; bus16.load  = 1'b0; bus16.din  = '0;
    bus10.en  = 1'b0; bus10.up  = 1'b0; bus10.load  = 1'b0; bus10.din  = '0;
    bus10s.en = 1'b0; bus10s.up = 1'b0; bus10s.load = 1'b0; bus10s.din = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle_all();
    step();
    step();

    // Reset state on all instances
    check("rst16_count", 32'(bus16.count), 0);
    check("rst16_carry", 32'(bus16.carry), 0);
    check("rst16_at_min", 32'(bus16.at_min), 1);
    check("rst16_at_max", 32'(bus16.at_max), 0);
    check("rst10_count", 32'(bus10.count), 0);
    check("rst10s_count", 32'(bus10s.count), 0);

    // Asynchronous reset with no clock edge, from count 5
    reset = 1'b1;
    bus16.load = 1'b1; bus16.din = 4'd5;
    step();
    idle_all();
    check("load5", 32'(bus16.count), 5);
    #1 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(bus16.count), 0);
    check("async_rst_carry", 32'(bus16.carry), 0);
    check("async_rst_at_min", 32'(bus16.at_min), 1);
    check("async_rst_at_max", 32'(bus16.at_max), 0);
    @(negedge clk);
    reset = 1'b1;
    bus16.en = 1'b1; bus16.up = 1'b1;
    step();
    check("first_edge_after_rst", 32'(bus16.count), 1);

    // Modulo-16 wrap over 16 up edges from 0
    idle_all();
    bus16.load = 1'b1; bus16.din = 4'd0;
    step();
    idle_all();
    bus16.en = 1'b1; bus16.up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("wrap16_count", 32'(bus16.count), 32'(i % 16));
      check("wrap16_carry", 32'(bus16.carry), (i == 16) ? 1 : 0);
      check("wrap16_at_max", 32'(bus16.at_max), (i == 15) ? 1 : 0);
    end

    // Modulo-10 wrap both directions
    idle_all();
    bus10.load = 1'b1; bus10.din = 4'd9;
    step();
    check("m10_at_max", 32'(bus10.at_max), 1);
    idle_all();
    bus10.en = 1'b1; bus10.up = 1'b1;
    step();
    check("m10_up_wrap_count", 32'(bus10.count), 0);
    check("m10_up_wrap_carry", 32'(bus10.carry), 1);
    bus10.up = 1'b0;
    step();
    check("m10_dn_wrap_count", 32'(bus10.count), 9);
    check("m10_dn_wrap_carry", 32'(bus10.carry), 1);
    idle_all();
    bus10.load = 1'b1; bus10.din = 4'd5;
    step();
    idle_all();
    bus10.en = 1'b1; bus10.up = 1'b0;
    step();
    check("m10_dn5_count", 32'(bus10.count), 4);
    check("m10_dn5_carry", 32'(bus10.carry), 0);
    bus10.up = 1'b1;
    step();
    check("m10_reverse_count", 32'(bus10.count), 5);

    // Saturating modulo-10: 12 up edges then 2 down edges at 0
    idle_all();
    bus10s.load = 1'b1; bus10s.din = 4'd0;
    step();
    idle_all();
    bus10s.en = 1'b1; bus10s.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("sat_up_count", 32'(bus10s.count), (i < 9) ? 32'(i) : 9);
      check("sat_up_carry", 32'(bus10s.carry), (i >= 10) ? 1 : 0);
    end
    idle_all();
    bus10s.load = 1'b1; bus10s.din = 4'd0;
    step();
    idle_all();
    bus10s.en = 1'b1; bus10s.up = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      check("sat_dn_count", 32'(bus10s.count), 0);
      check("sat_dn_carry", 32'(bus10s.carry), 1);
    end

    // Load beats enable; out-of-range load clamps
    idle_all();
    bus16.load = 1'b1; bus16.din = 4'd7; bus16.en = 1'b1; bus16.up = 1'b1;
    bus10.load = 1'b1; bus10.din = 4'd12;
    bus10s.load = 1'b1; bus10s.din = 4'd15; bus10s.en = 1'b1; bus10s.up = 1'b1;
    step();
    check("load_prio_count", 32'(bus16.count), 7);
    check("load_prio_carry", 32'(bus16.carry), 0);
    check("load_clamp10", 32'(bus10.count), 9);
    check("load_clamp10s", 32'(bus10s.count), 9);
    check("load_clamp10s_carry", 32'(bus10s.carry), 0);

    // Hold with en=0, then reset mid-cycle
    idle_all();
    bus16.load = 1'b1; bus16.din = 4'd3;
    step();
    idle_all();
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_count", 32'(bus16.count), 3);
      check("hold_carry", 32'(bus16.carry), 0);
    end
    bus16.en = 1'b1; bus16.up = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus16.count), 0);
    check("mid_rst_carry", 32'(bus16.carry), 0);
    check("mid_rst_count10", 32'(bus10.count), 0);
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
